// File: rtl/enemy_kill_tracker.sv
// Enemy alive map, kill scoring and level-clear sequencing.
// Optional score accumulation is enabled by ENEMY_KILL_TRACKER_SCORE_EN.
module enemy_kill_tracker #(
    parameter int AMOUNT_OF_ENEMIES  = 2,
    parameter int KILL_SCORE         = 10,
    parameter int LEVEL_DELAY_FRAMES = 60
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         startOfFrame,
    input  logic                         enemyDrawReq,
    input  logic [3:0]                   drawingRequestorId,
    input  logic [2:0]                   shotCollision,
    input  logic                         pause,
    output logic [AMOUNT_OF_ENEMIES-1:0] aliveMap,
    output logic                         visibleDrawReq,
    output logic                         killPulse,
    output logic [15:0]                  score,
    output logic [7:0]                   levelNum,
    output logic                         newLevel
);

    typedef enum logic [1:0] {PLAY, CLEARED, NEWLVL} stateType;

    localparam logic [AMOUNT_OF_ENEMIES-1:0] ALL_ALIVE = '1;
    localparam logic [7:0] LAST_FRAME = 8'(LEVEL_DELAY_FRAMES - 1);

    stateType                     state, stateNext;
    logic [7:0]                   frameCount, frameCountNext;
    logic [AMOUNT_OF_ENEMIES-1:0] aliveNext, killMask;
    logic [7:0]                   levelNext;
    logic [15:0]                  aliveExt, killExt;
    logic                         idValid, hit;

    // Pad alive map to the full id space so any 4-bit id indexes safely
    always_comb begin
        aliveExt = '0;
        aliveExt[AMOUNT_OF_ENEMIES-1:0] = aliveMap;
    end

    assign idValid = {28'b0, drawingRequestorId} < 32'(AMOUNT_OF_ENEMIES);
    assign visibleDrawReq = enemyDrawReq & idValid
                          & aliveExt[drawingRequestorId];
    assign hit = visibleDrawReq & (shotCollision != 3'b000)
               & ~pause & (state == PLAY);

    assign killExt  = 16'(hit) << drawingRequestorId;
    assign killMask = killExt[AMOUNT_OF_ENEMIES-1:0];
    assign newLevel = (state == NEWLVL);

    always_comb begin
        stateNext      = state;
        frameCountNext = frameCount;
        aliveNext      = aliveMap & ~killMask;
        levelNext      = levelNum;
        unique case (state)
            PLAY: begin
                if (hit && aliveNext == '0) begin
                    stateNext      = CLEARED;
                    frameCountNext = '0;
                end
            end
            CLEARED: begin
                if (startOfFrame && !pause) begin
                    if (frameCount == LAST_FRAME)
                        stateNext = NEWLVL;
                    else
                        frameCountNext = frameCount + 8'd1;
                end
            end
            NEWLVL: begin
                aliveNext = ALL_ALIVE;
                levelNext = (levelNum == 8'hFF) ? levelNum
                                                : levelNum + 8'd1;
                stateNext = PLAY;
            end
            default: stateNext = PLAY;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= PLAY;
            frameCount <= '0;
            aliveMap   <= ALL_ALIVE;
            levelNum   <= 8'd1;
            killPulse  <= 1'b0;
        end else begin
            state      <= stateNext;
            frameCount <= frameCountNext;
            aliveMap   <= aliveNext;
            levelNum   <= levelNext;
            killPulse  <= hit;
        end
    end

`ifdef ENEMY_KILL_TRACKER_SCORE_EN
    logic [15:0] scoreReg;
    logic [16:0] scoreSum;

    assign scoreSum = {1'b0, scoreReg} + 17'(KILL_SCORE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            scoreReg <= '0;
        else if (hit)
            scoreReg <= scoreSum[16] ? 16'hFFFF : scoreSum[15:0];
    end

    assign score = scoreReg;
`else
    assign score = '0;
`endif

endmodule

// File: doc/enemy_kill_tracker.md
ENEMY_KILL_TRACKER -- requirements
Module: enemy_kill_tracker

Interface
REQ-001 Parameter AMOUNT_OF_ENEMIES, default 2, number of tracked enemies (range 1..16).
REQ-002 Parameter KILL_SCORE, default 10, points added per kill.
REQ-003 Parameter LEVEL_DELAY_FRAMES, default 60, frames between last kill and newLevel (range 1..255).
REQ-004 clk  input  1  system clock; one clock; all state on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 startOfFrame  input  1  one-cycle pulse per VGA frame.
REQ-007 enemyDrawReq  input  1  enemy body pixel request from the enemy stock manager.
REQ-008 drawingRequestorId  input  4  index of the enemy owning the current pixel.
REQ-009 shotCollision  input  3  nonzero = a shot overlaps the current pixel.
REQ-010 pause  input  1  game paused.
REQ-011 aliveMap  output  AMOUNT_OF_ENEMIES  bit i = enemy i alive.
REQ-012 visibleDrawReq  output  1  enemyDrawReq gated by alive status of drawingRequestorId (combinational).
REQ-013 killPulse  output  1  one-cycle pulse per kill.
REQ-014 score  output  16  accumulated score.
REQ-015 levelNum  output  8  current level number.
REQ-016 newLevel  output  1  one-cycle pulse requesting enemy position restart.

Function
REQ-017 Valid hit = enemyDrawReq & (shotCollision!=0) & drawingRequestorId<AMOUNT_OF_ENEMIES & aliveMap[id] & !pause & state==PLAY.
REQ-018 On a valid hit, aliveMap[id] SHALL clear and killPulse SHALL assert on the next clock edge (1-cycle latency), for exactly one cycle.
REQ-019 Further hit pixels on a dead enemy SHALL be ignored (at most one kill per enemy per life).
REQ-020 visibleDrawReq = enemyDrawReq & id<AMOUNT_OF_ENEMIES & aliveMap[id]; out-of-range id yields 0.
REQ-021 score SHALL add KILL_SCORE per kill, saturating at 16'hFFFF.
REQ-022 States: PLAY, CLEARED, NEWLVL; reset state PLAY.
REQ-023 PLAY->CLEARED on the edge where aliveMap becomes all zero; frame counter cleared to 0.
REQ-024 CLEARED: counter increments on each startOfFrame while !pause; on the LEVEL_DELAY_FRAMES-th counted pulse go to NEWLVL.
REQ-025 NEWLVL lasts one cycle: newLevel=1, aliveMap set to all ones, levelNum incremented (saturating at 255), then PLAY.
REQ-026 pause SHALL freeze the frame counter and block hits; no state change except via reset.
REQ-027 startOfFrame coincident with the last kill SHALL NOT be counted.

Reset
REQ-028 While reset=1 (asynchronous): state=PLAY, aliveMap=all ones, killPulse=0, newLevel=0, score=0, levelNum=1, counter=0.
REQ-029 Reset mid-CLEARED SHALL abort the delay with no newLevel pulse.

Configuration
REQ-030 Macro ENEMY_KILL_TRACKER_SCORE_EN: defined -> score accumulates per REQ-021; undefined -> score tied to 0 and no score register synthesised; all other behaviour identical.

Verification
REQ-031 Reset release, no stimulus -> aliveMap=2'b11, levelNum=1, score=0, newLevel never asserts.
REQ-032 id=0, enemyDrawReq=1, shotCollision=3'b001 for 5 consecutive cycles -> one killPulse, aliveMap=2'b10, score=10.
REQ-033 Same hit with pause=1 -> no killPulse, aliveMap=2'b11; with id=5 -> no effect, visibleDrawReq=0.
REQ-034 Kill enemy 0 then 1 -> CLEARED; after 60 startOfFrame pulses, newLevel one cycle, aliveMap=2'b11, levelNum=2, score=20.
REQ-035 In CLEARED, pause asserted for 10 frames after frame 30 -> newLevel at the 60th unpaused pulse.
REQ-036 Reset asserted at frame 20 of CLEARED -> no newLevel, aliveMap=2'b11, score=0, levelNum=1.
